// File: rtl/bridge_pkg.sv
// Shared types and constants for the memory-stage bridge (mem_bridge_ctrl).
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DM_ACC   = 3'd1,
    ST_DEV_WAIT = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TGT_DM   = 2'd0,
    TGT_T0   = 2'd1,
    TGT_T1   = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  localparam logic [31:0] DM_TOP  = 32'h0000_2fff;
  localparam logic [31:0] T0_BASE = 32'h0000_7f00;
  localparam logic [31:0] T0_TOP  = 32'h0000_7f0b;
  localparam logic [31:0] T1_BASE = 32'h0000_7f10;
  localparam logic [31:0] T1_TOP  = 32'h0000_7f1b;

  localparam logic [5:0] EXC_ADEL = 6'b1_00100;
  localparam logic [5:0] EXC_ADES = 6'b1_00101;

  // Address-exception code for a faulting access: store or load flavour.
  function automatic logic [5:0] exc_code(input logic we);
    return we ? EXC_ADES : EXC_ADEL;
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: picks DM / timer 0 / timer 1 and flags
// unmapped, misaligned, sub-word-to-timer and store-to-count accesses.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter logic [31:0] DM_TOP = bridge_pkg::DM_TOP
) (
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  output tgt_e        tgt,
  output logic        fault
);

  logic is_word;
  logic is_half;
  logic is_timer;
  logic misalign;

  // Target select and fault classification.
  always_comb begin
    is_word = (be == 4'b1111);
    is_half = (be == 4'b0011) || (be == 4'b1100);

    if (addr <= DM_TOP) begin
      tgt = TGT_DM;
    end else if ((addr >= T0_BASE) && (addr <= T0_TOP)) begin
      tgt = TGT_T0;
    end else if ((addr >= T1_BASE) && (addr <= T1_TOP)) begin
      tgt = TGT_T1;
    end else begin
      tgt = TGT_NONE;
    end

    is_timer = (tgt == TGT_T0) || (tgt == TGT_T1);
    misalign = (is_word && (addr[1:0] != 2'b00)) || (is_half && (addr[0] != 1'b0));

    // Timers are word-only, and their count register (offset 2) is read-only.
    fault = (tgt == TGT_NONE) || misalign
         || (is_timer && !is_word)
         || (is_timer && we && (addr[3:2] == 2'd2));
  end

endmodule

// File: rtl/mem_bridge_ctrl.sv
// M-stage bus bridge / sequencer: routes one load/store to DM or a timer,
// stalls the pipeline until done, returns rdata or an address exception.
// Optional feature macro: BRIDGE_TIMEOUT_EN (device access timeout -> ERR).
module mem_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [31:0] DM_TOP         = bridge_pkg::DM_TOP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_be,
  output logic        m_stall,
  output logic        m_resp,
  output logic [31:0] m_rdata,
  output logic [5:0]  m_exc,
  output logic        dm_en,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  dev_req,
  output logic        dev_we,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  input  logic [1:0]  dev_ack
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;   // one-hot timer select, 2'b00 means DM
  logic        dev_done_s;
  logic        timeout_s;

  tgt_e        dec_tgt;
  logic        dec_fault;

  bridge_addr_decode #(
    .DM_TOP (DM_TOP)
  ) u_decode (
    .addr  (m_addr),
    .we    (m_we),
    .be    (m_be),
    .tgt   (dec_tgt),
    .fault (dec_fault)
  );

  // Only the ack bit of the selected timer completes the access.
  assign dev_done_s = ((sel_q & dev_ack) != 2'b00);

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] tmo_q, tmo_d;

  // Timeout counter: counts DEV_WAIT cycles, held at zero elsewhere.
  always_comb begin
    if (state_q == ST_DEV_WAIT) begin
      tmo_d = tmo_q + 4'd1;
    end else begin
      tmo_d = 4'd0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 4'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout_s = (tmo_q == TMO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic and request latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          be_d    = m_be;
          we_d    = m_we;
          rdata_d = 32'h0000_0000;
          if (dec_fault) begin
            sel_d   = 2'b00;
            state_d = ST_ERR;
          end else begin
            case (dec_tgt)
              TGT_T0: begin
                sel_d   = 2'b01;
                state_d = ST_DEV_WAIT;
              end
              TGT_T1: begin
                sel_d   = 2'b10;
                state_d = ST_DEV_WAIT;
              end
              default: begin
                sel_d   = 2'b00;
                state_d = ST_DM_ACC;
              end
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DM_ACC: begin
        state_d = ST_DONE;
      end
      ST_DEV_WAIT: begin
        if (dev_done_s) begin
          rdata_d = sel_q[1] ? dev_rdata1 : dev_rdata0;
          state_d = ST_DONE;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DEV_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
    end
  end

  // Bus-side and pipeline-side outputs decoded from registered state.
  // DM read data arrives during DONE (DM registers it off the DM_ACC strobe),
  // so a DM load forwards dm_rdata in that cycle; timer data was latched on ack.
  always_comb begin
    dm_en     = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 32'h0000_0000;
    dm_wdata  = 32'h0000_0000;
    dm_be     = 4'b0000;
    dev_req   = 2'b00;
    dev_we    = 1'b0;
    dev_addr  = 2'b00;
    dev_wdata = 32'h0000_0000;
    m_resp    = 1'b0;
    m_rdata   = 32'h0000_0000;
    m_exc     = 6'b00_0000;
    case (state_q)
      ST_DM_ACC: begin
        dm_en    = 1'b1;
        dm_we    = we_q;
        dm_addr  = addr_q;
        dm_wdata = wdata_q;
        dm_be    = be_q;
      end
      ST_DEV_WAIT: begin
        dev_req   = sel_q;
        dev_we    = we_q;
        dev_addr  = addr_q[3:2];
        dev_wdata = wdata_q;
      end
      ST_DONE: begin
        m_resp = 1'b1;
        if (we_q) begin
          m_rdata = 32'h0000_0000;
        end else if (sel_q == 2'b00) begin
          m_rdata = dm_rdata;
        end else begin
          m_rdata = rdata_q;
        end
      end
      ST_ERR: begin
        m_resp = 1'b1;
        m_exc  = exc_code(we_q);
      end
      default: begin
        m_resp = 1'b0;
      end
    endcase
  end

  assign m_stall = m_req & ~m_resp;

endmodule

// File: tb/tb_mem_bridge_ctrl.sv
// Scoreboard bench for mem_bridge_ctrl: stimulus pushes expected {rdata,exc},
// a monitor pops and compares on every m_resp.
module tb_mem_bridge_ctrl;

  localparam logic [5:0] ADEL = 6'b100100;
  localparam logic [5:0] ADES = 6'b100101;

  typedef struct {
    logic [31:0] rd;
    logic [5:0]  exc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_stall, m_resp;
  logic [31:0] m_rdata;
  logic [5:0]  m_exc;
  logic        dm_en, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic [1:0]  dev_req;
  logic        dev_we;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata0, dev_rdata1;
  logic [1:0]  dev_ack;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // timer responder controls and observations
  int ack_wait0 = 0, ack_wait1 = 0;
  bit stray0 = 1'b0;
  int cnt0 = 0, cnt1 = 0;
  int dev_hi = 0, dm_en_cnt = 0;
  logic [1:0]  obs_req;
  logic [1:0]  obs_addr;
  logic        obs_we;
  logic [31:0] obs_wdata;
  int hang_cycles;

  logic [31:0] dm_mem [0:63];

  mem_bridge_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_stall(m_stall), .m_resp(m_resp), .m_rdata(m_rdata), .m_exc(m_exc),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // DM model: registered read (read-first), byte-enabled write.
  always @(posedge clk) begin
    if (dm_en) begin
      dm_rdata <= dm_mem[dm_addr[7:2]];
      if (dm_we) begin
        for (int b = 0; b < 4; b++) begin
          if (dm_be[b]) dm_mem[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
        end
      end
    end
  end

  // Timer responder: ack in the ack_waitN-th cycle of dev_req (0 = never).
  initial begin
    dev_ack = 2'b00;
    forever begin
      @(negedge clk);
      if (dev_req[0]) cnt0++; else cnt0 = 0;
      if (dev_req[1]) cnt1++; else cnt1 = 0;
      if (dev_req != 2'b00) begin
        dev_hi++;
        obs_req   = dev_req;
        obs_addr  = dev_addr;
        obs_we    = dev_we;
        obs_wdata = dev_wdata;
      end
      if (dm_en) dm_en_cnt++;
      dev_ack[0] = (dev_req[0] && ack_wait0 != 0 && cnt0 == ack_wait0) || (stray0 && dev_req[1]);
      dev_ack[1] = dev_req[1] && ack_wait1 != 0 && cnt1 == ack_wait1;
    end
  end

  // Monitor: pop and compare on every response; outputs must idle at zero otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (m_resp) begin
          if (exp_q.size() == 0) begin
            chk("unexpected m_resp", {26'd0, m_exc, m_rdata}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, " rdata"}, {32'd0, m_rdata}, {32'd0, e.rd});
            chk({e.name, " exc"}, {58'd0, m_exc}, {58'd0, e.exc});
          end
        end else begin
          chk("idle rdata/exc", {26'd0, m_exc, m_rdata}, 64'd0);
        end
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int exp_lat, input logic [31:0] exp_rd,
                        input logic [5:0] exp_exc, input string name);
    int lat;
    bit done;
    exp_q.push_back('{rd: exp_rd, exc: exp_exc, name: name});
    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (m_resp) done = 1'b1;
      else chk({name, " stall"}, {63'd0, m_stall}, 64'd1);
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " stall at resp"}, {63'd0, m_stall}, 64'd0);
    m_req = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0;
  endtask

  initial begin
    int hi0, dm0;
    for (int i = 0; i < 64; i++) dm_mem[i] = 32'h0000_0000;
    dm_mem[4]  = 32'hdead_beef;
    dm_mem[63] = 32'h0bad_cafe;
    dm_rdata   = 32'h0000_0000;
    dev_rdata0 = 32'h1111_2222;
    dev_rdata1 = 32'h0000_0055;
    reset_n = 1'b0;
    m_req = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0;
    #12;
    chk("reset outputs", {63'd0, |{m_stall, m_resp, m_rdata, m_exc, dm_en, dm_we, dm_addr,
        dm_wdata, dm_be, dev_req, dev_we, dev_addr, dev_wdata}}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // DM accesses
    access(1'b0, 32'h0000_0010, 32'd0, 4'b1111, 2, 32'hdead_beef, 6'd0, "dm load 0x10");
    access(1'b1, 32'h0000_0020, 32'hcafe_f00d, 4'b1111, 2, 32'd0, 6'd0, "dm store 0x20");
    access(1'b1, 32'h0000_0022, 32'h00aa_0000, 4'b0100, 2, 32'd0, 6'd0, "dm store byte 0x22");
    access(1'b0, 32'h0000_0020, 32'd0, 4'b1111, 2, 32'hcaaa_f00d, 6'd0, "dm load 0x20");
    access(1'b0, 32'h0000_2ffc, 32'd0, 4'b1111, 2, 32'h0bad_cafe, 6'd0, "dm load top word");

    // Timer 1 store, ack in third wait cycle
    ack_wait1 = 3;
    hi0 = dev_hi;
    access(1'b1, 32'h0000_7f14, 32'h0000_1234, 4'b1111, 4, 32'd0, 6'd0, "t1 store 0x7f14");
    chk("t1 store dev_req cycles", 64'(dev_hi - hi0), 64'd3);
    chk("t1 store dev_req", {62'd0, obs_req}, 64'd2);
    chk("t1 store dev_addr", {62'd0, obs_addr}, 64'd1);
    chk("t1 store dev_we", {63'd0, obs_we}, 64'd1);
    chk("t1 store dev_wdata", {32'd0, obs_wdata}, 64'h1234);

    // Timer 1 load with stray ack on timer 0's bit
    ack_wait1 = 2;
    stray0 = 1'b1;
    access(1'b0, 32'h0000_7f18, 32'd0, 4'b1111, 3, 32'h0000_0055, 6'd0, "t1 load stray ack");
    stray0 = 1'b0;

    // Timer 0 load, ack in first wait cycle
    ack_wait0 = 1;
    access(1'b0, 32'h0000_7f04, 32'd0, 4'b1111, 2, 32'h1111_2222, 6'd0, "t0 load 0x7f04");

    // Faults: no strobes at all
    hi0 = dev_hi;
    dm0 = dm_en_cnt;
    access(1'b0, 32'h0000_3000, 32'd0, 4'b1111, 1, 32'd0, ADEL, "load past DM_TOP");
    access(1'b1, 32'h0000_7f08, 32'h5, 4'b1111, 1, 32'd0, ADES, "store t0 count");
    access(1'b1, 32'h0000_0003, 32'h5, 4'b1100, 1, 32'd0, ADES, "store half 0x3");
    access(1'b0, 32'h0000_0012, 32'd0, 4'b1111, 1, 32'd0, ADEL, "load word misaligned");
    access(1'b0, 32'h0000_7f00, 32'd0, 4'b0001, 1, 32'd0, ADEL, "load byte timer");
    access(1'b0, 32'h0000_7f0c, 32'd0, 4'b1111, 1, 32'd0, ADEL, "load gap 0x7f0c");
    chk("faults dm_en count", 64'(dm_en_cnt - dm0), 64'd0);
    chk("faults dev_req count", 64'(dev_hi - hi0), 64'd0);

    // Unacknowledged timer access
    ack_wait0 = 0;
`ifdef BRIDGE_TIMEOUT_EN
    hi0 = dev_hi;
    access(1'b0, 32'h0000_7f00, 32'd0, 4'b1111, 16, 32'd0, ADEL, "t0 load timeout");
    chk("timeout dev_req cycles", 64'(dev_hi - hi0), 64'd15);
    hang_cycles = 6;
`else
    hang_cycles = 30;
`endif
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_7f00; m_be = 4'b1111;
    repeat (hang_cycles) @(negedge clk);
    chk("hang dev_req", {62'd0, dev_req}, 64'd1);
    chk("hang m_stall", {63'd0, m_stall}, 64'd1);
    #2;
    reset_n = 1'b0;
    m_req = 1'b0; m_addr = 32'd0; m_be = 4'd0;
    #1;
    chk("reset mid-wait dev_req", {62'd0, dev_req}, 64'd0);
    chk("reset mid-wait m_stall", {63'd0, m_stall}, 64'd0);
    chk("reset mid-wait m_resp", {63'd0, m_resp}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b0, 32'h0000_0010, 32'd0, 4'b1111, 2, 32'hdead_beef, 6'd0, "dm load after reset");

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge_ctrl.md
# mem_bridge_ctrl

Memory-stage bus bridge and sequencer for the P7 CPU. It takes one load/store request from the M stage and decodes the address to data memory (DM), timer 0 or timer 1. It runs the access handshake with the selected target, stalls the pipeline until the access completes, and returns read data or an address-exception code (1_00100 load, 1_00101 store) to the CP0/exception path.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: device cycles allowed before a bus error (used only with the timeout feature).
- DM_TOP, 32'h0000_2fff: last DM byte address.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- m_req  in  1  M stage holds a valid load/store.
- m_we  in  1  1 = store, 0 = load.
- m_addr  in  32  byte address (ALU result).
- m_wdata  in  32  store data, already lane-aligned.
- m_be  in  4  byte enables.
- m_stall  out  1  freeze F/D/E/M stages.
- m_resp  out  1  one-cycle completion pulse.
- m_rdata  out  32  load data, valid with m_resp.
- m_exc  out  6  {1, ExcCode} when the access faults, else 0; valid with m_resp.
- dm_en, dm_we  out  1, 1  DM strobe and write.
- dm_addr  out  32  DM address.
- dm_wdata  out  32  DM write data.
- dm_be  out  4  DM byte enables.
- dm_rdata  in  32  DM read data, registered, one cycle after dm_en.
- dev_req  out  2  one-hot request, bit0 timer 0, bit1 timer 1.
- dev_we  out  1  device write.
- dev_addr  out  2  word offset, addr[3:2].
- dev_wdata  out  32  device write data.
- dev_rdata0, dev_rdata1  in  32  timer read data.
- dev_ack  in  2  per-timer acknowledge.

## Operation
- Address map:
  - DM: 0x0000 to DM_TOP.
  - Timer 0: 0x7f00 to 0x7f0b.
  - Timer 1: 0x7f10 to 0x7f1b.
  - Any other address faults.
- Faults, all decided in IDLE:
  - Unmapped address.
  - Misalignment: word access with m_be=1111 and addr[1:0]≠0; half access with addr[0]≠0.
  - Sub-word access (m_be≠1111) to a timer.
  - Store to timer offset 2 (count register, addr[3:2]=2).
- FSM states: IDLE, DM_ACC, DEV_WAIT, DONE, ERR.
- IDLE:
  - m_req with a fault → ERR.
  - m_req to DM → DM_ACC.
  - m_req to a timer → DEV_WAIT; latch addr, we, wdata and the select.
- DM_ACC: dm_en=1 for one cycle → DONE. Load data is captured from dm_rdata on entry to DONE.
- DEV_WAIT:
  - Hold dev_req, dev_we, dev_addr and dev_wdata stable until the matching dev_ack bit is 1.
  - On ack: capture rdata, go to DONE.
  - An ack on the non-selected bit is ignored.
- DONE: m_resp=1, m_exc=0 → IDLE.
- ERR: m_resp=1, m_exc=1_00100 (load) or 1_00101 (store), m_rdata=0; no DM or device strobe issued → IDLE.
- m_stall = m_req & ~m_resp, combinational.
- A new m_req is sampled only in IDLE.

## Timing
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - All outputs 0, including m_stall (m_req is also 0 then).
  - The timeout counter clears.
  - A reset during DEV_WAIT drops dev_req immediately.
- Latency from the m_req edge to the m_resp cycle:
  - DM: 2 cycles (IDLE→DM_ACC→DONE).
  - Fault: 1 cycle.
  - Device: 2 + wait cycles; an ack in the first DEV_WAIT cycle gives 2.
- m_rdata and m_exc are valid only during the m_resp cycle; they are 0 otherwise.
- dev_req rises on the cycle after acceptance and falls on the cycle after ack.

## Configuration
- BRIDGE_TIMEOUT_EN defined:
  - A 4-bit counter runs in DEV_WAIT.
  - When it reaches TIMEOUT_CYCLES with no ack: dev_req drops and the FSM goes to ERR, using the load/store code of the access.
  - The counter clears on entering DEV_WAIT.
- BRIDGE_TIMEOUT_EN undefined: DEV_WAIT waits indefinitely, and the counter logic is absent.

## Structure
- bridge_pkg holds:
  - the state enum;
  - the address constants (DM_TOP, T0_BASE/T0_TOP, T1_BASE/T1_TOP);
  - EXC_ADEL=6'b1_00100 and EXC_ADES=6'b1_00101.
- Sub-module bridge_addr_decode is purely combinational. It takes addr, we and be, and produces the target select and the fault flag.

## Test plan
- Load word at 0x0000_0010 from DM preloaded with 0xdead_beef → m_stall for 2 cycles, then m_resp with m_rdata=0xdead_beef, m_exc=0.
- Store 0x1234 to 0x7f14 (timer 1 offset 1), ack after 3 wait cycles → dev_req=10 held 3 cycles, dev_addr=1, dev_we=1, m_resp on the following cycle.
- Load word at 0x0000_3000 → m_resp after 1 cycle, m_exc=6'b100100, dm_en and dev_req never asserted.
- Store word to 0x7f08 (timer 0 count register) → m_exc=6'b100101; store half to 0x0000_0003 → m_exc=6'b100101.
- With BRIDGE_TIMEOUT_EN and no ack on a 0x7f00 load → dev_req drops after 15 cycles, m_exc=6'b100100; without the macro, m_stall stays high indefinitely.
- Assert reset_n=0 mid DEV_WAIT → dev_req, m_stall and m_resp go to 0 immediately; after release a DM load completes normally.
